// File: rtl/boreal_bus_initiator.sv
// Single-outstanding bus initiator: host command/response channels to a single-beat CPU bus port.
// Optional statistics counters are compiled in with BOREAL_BUS_INIT_STATS_EN.
module boreal_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        bus_req_valid,
  output logic        bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata,
  input  logic        bus_resp_err,
  output logic [7:0]  stray_cnt
`ifdef BOREAL_BUS_INIT_STATS_EN
  ,
  output logic [31:0] stat_txn,
  output logic [15:0] stat_err,
  output logic [15:0] stat_to
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [TO_W-1:0] LastCnt = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic            req_we_q, req_we_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [31:0]     req_wdata_q, req_wdata_d;
  logic [3:0]      req_wstrb_q, req_wstrb_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_to_q, rsp_to_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0]      stray_q, stray_d;

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    cnt_d       = cnt_q;
    stray_d     = stray_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned: answer locally, bus request fields keep their previous values
            state_d     = StResp;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_to_d    = 1'b0;
          end else begin
            state_d     = StIssue;
            req_we_d    = cmd_we;
            req_addr_d  = cmd_addr;
            req_wdata_d = cmd_wdata;
            req_wstrb_d = cmd_we ? cmd_wstrb : 4'h0;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus_resp_valid) begin
          state_d     = StResp;
          rsp_rdata_d = req_we_q ? 32'h0 : bus_resp_rdata;
          rsp_err_d   = bus_resp_err;
          rsp_to_d    = 1'b0;
        end else if (cnt_q == LastCnt) begin
          state_d     = StResp;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          rsp_to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          rsp_to_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus_resp_valid && (state_q != StWait) && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      cnt_q       <= '0;
      stray_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      cnt_q       <= cnt_d;
      stray_q     <= stray_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign rsp_valid     = (state_q == StResp);
  assign bus_req_valid = (state_q == StIssue);
  assign bus_req_we    = req_we_q;
  assign bus_req_addr  = req_addr_q;
  assign bus_req_wdata = req_wdata_q;
  assign bus_req_wstrb = req_wstrb_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_timeout   = rsp_to_q;
  assign stray_cnt     = stray_q;

`ifdef BOREAL_BUS_INIT_STATS_EN
  logic        resp_entry;
  logic [31:0] stat_txn_q;
  logic [15:0] stat_err_q, stat_to_q;

  assign resp_entry = (state_q != StResp) && (state_d == StResp);

  // A transaction counts as completed only when the interconnect actually answered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_txn_q <= '0;
      stat_err_q <= '0;
      stat_to_q  <= '0;
    end else if (resp_entry) begin
      if (state_q == StWait && bus_resp_valid) stat_txn_q <= stat_txn_q + 32'd1;
      if (rsp_err_d) stat_err_q <= stat_err_q + 16'd1;
      if (rsp_to_d)  stat_to_q  <= stat_to_q + 16'd1;
    end
  end

  assign stat_txn = stat_txn_q;
  assign stat_err = stat_err_q;
  assign stat_to  = stat_to_q;
`endif

endmodule

// File: tb/tb_boreal_bus_initiator.sv
// Self-checking bench for boreal_bus_initiator: directed plus randomized transactions checked
// against a transaction-level model of the expected response, latency and stray count.
module tb_boreal_bus_initiator;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        bus_req_valid;
  logic        bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_valid = 1'b0;
  logic [31:0] bus_resp_rdata = '0;
  logic        bus_resp_err = 1'b0;
  logic [7:0]  stray_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: last request put on the bus and the expected stray count
  logic        last_we = 1'b0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;
  int          stray_exp = 0;

  boreal_bus_initiator #(
    .TIMEOUT_CYCLES(TO),
    .TO_W          (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .rsp_timeout   (rsp_timeout),
    .bus_req_valid (bus_req_valid),
    .bus_req_we    (bus_req_we),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_wstrb (bus_req_wstrb),
    .bus_resp_valid(bus_resp_valid),
    .bus_resp_rdata(bus_resp_rdata),
    .bus_resp_err  (bus_resp_err),
    .stray_cnt     (stray_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_req_valid"}, 32'(bus_req_valid), 32'd0);
    chk({tag, "_req_we"}, 32'(bus_req_we), 32'd0);
    chk({tag, "_req_addr"}, bus_req_addr, 32'd0);
    chk({tag, "_req_wdata"}, bus_req_wdata, 32'd0);
    chk({tag, "_req_wstrb"}, 32'(bus_req_wstrb), 32'd0);
    chk({tag, "_stray"}, 32'(stray_cnt), 32'd0);
  endtask

  // resp_at: WAIT-cycle index (0-based) at which the bus answers; <0 or >=TO means no answer
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int resp_at, input logic [31:0] rd,
                         input logic be, input int hold, input bit busy_cmd);
    logic        mis;
    logic [31:0] exp_rd;
    logic        exp_err, exp_to;
    int          exp_seen, seen;
    mis = (addr[1:0] != 2'b00);
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (mis) begin
      exp_rd  = '0;
      exp_err = 1'b1;
      exp_to  = 1'b0;
      chk("mis_no_req", 32'(bus_req_valid), 32'd0);
      chk("mis_rsp_next_cycle", 32'(rsp_valid), 32'd1);
    end else begin
      last_we    = we;
      last_addr  = addr;
      last_wdata = wdata;
      last_wstrb = we ? wstrb : 4'h0;
      chk("req_valid_t1", 32'(bus_req_valid), 32'd1);
      chk("req_we", 32'(bus_req_we), 32'(we));
      chk("req_addr", bus_req_addr, addr);
      chk("req_wdata", bus_req_wdata, wdata);
      chk("req_wstrb", 32'(bus_req_wstrb), 32'(last_wstrb));
      if (resp_at >= 0 && resp_at < TO) begin
        exp_rd   = we ? 32'h0 : rd;
        exp_err  = be;
        exp_to   = 1'b0;
        exp_seen = resp_at + 1;
      end else begin
        exp_rd   = '0;
        exp_err  = 1'b0;
        exp_to   = 1'b1;
        exp_seen = TO;
      end
      seen = -1;
      for (int j = 0; j < TO + 4; j++) begin
        @(negedge clk);
        bus_resp_valid = 1'b0;
        if (rsp_valid) begin
          seen = j;
          break;
        end
        if (j == 0) chk("req_one_cycle", 32'(bus_req_valid), 32'd0);
        if (j == resp_at) begin
          bus_resp_valid = 1'b1;
          bus_resp_rdata = rd;
          bus_resp_err   = be;
        end
      end
      chk("rsp_latency", 32'(seen), 32'(exp_seen));
    end
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    chk("req_addr_hold", bus_req_addr, last_addr);
    chk("req_wstrb_hold", 32'(bus_req_wstrb), 32'(last_wstrb));
    for (int h = 0; h < hold; h++) begin
      if (busy_cmd) begin
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h2000_0000 + 32'(h * 4);
      end
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, exp_rd);
      chk("hold_rsp_flags", {30'd0, rsp_err, rsp_timeout}, {30'd0, exp_err, exp_to});
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_no_req", 32'(bus_req_valid), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
    chk("rsp_done_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic stray_pulse();
    @(negedge clk);
    bus_resp_valid = 1'b1;
    bus_resp_rdata = $urandom;
    if (stray_exp < 255) stray_exp++;
    @(negedge clk);
    bus_resp_valid = 1'b0;
  endtask

  initial begin
    logic        r_we, r_be;
    logic [31:0] r_addr, r_wdata, r_rd;
    logic [3:0]  r_wstrb;
    int          r_at;

    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    // Write answered after one cycle, then read answered after three
    run_txn(1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 4'hF, 1, 32'h1234_5678, 1'b0, 0, 1'b0);
    run_txn(1'b0, 32'h1000_0000, 32'h5555_5555, 4'hA, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    // Misaligned read never reaches the bus
    run_txn(1'b0, 32'h1000_0002, 32'h0, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0);
    // Bus error and the same-cycle response-versus-timeout tie
    run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b1, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, TO - 1, 32'hA5A5_0001, 1'b0, 0, 1'b0);
    // Timeout, then the late response arrives as a stray
    run_txn(1'b0, 32'h0000_0048, 32'h0, 4'h0, -1, 32'h0, 1'b0, 0, 1'b0);
    stray_pulse();
    @(negedge clk);
    chk("stray_after_timeout", 32'(stray_cnt), 32'(stray_exp));
    // Host stalls the response channel while offering another command
    run_txn(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'h3, 2, 32'h0, 1'b0, 10, 1'b1);

    // Reset in the middle of WAIT
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h3000_0000;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    stray_exp  = 0;
    last_we    = 1'b0;
    last_addr  = '0;
    last_wdata = '0;
    last_wstrb = '0;
    chk_reset_outputs("mid_wait_reset");
    @(negedge clk);
    rst = 1'b0;
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'h0, 2, 32'h7777_8888, 1'b0, 0, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      r_we    = 1'($urandom);
      r_addr  = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
      r_wdata = $urandom;
      r_wstrb = 4'($urandom);
      r_rd    = $urandom;
      r_be    = ($urandom_range(0, 4) == 0);
      r_at    = int'($urandom_range(0, TO + 2)) - 1;
      run_txn(r_we, r_addr, r_wdata, r_wstrb, r_at, r_rd, r_be, int'($urandom_range(0, 3)),
              1'($urandom));
      if ($urandom_range(0, 4) == 0) stray_pulse();
    end
    @(negedge clk);
    chk("stray_random", 32'(stray_cnt), 32'(stray_exp));

    // Saturation of the stray counter
    for (int s = 0; s < 260; s++) stray_pulse();
    @(negedge clk);
    chk("stray_saturate", 32'(stray_cnt), 32'(stray_exp));
    run_txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 32'h0101_0101, 1'b0, 0, 1'b0);
    chk("stray_still_sat", 32'(stray_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
